rs_seq_divider: RTL and testbench



---
 rtl/rs_seq_divider.sv | 95 +++++++++
 tb/tb_rs_seq_divider.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_seq_divider.sv
// Sequential unsigned restoring divider: one trial subtraction per clock,
// producing quotient and remainder after WIDTH iterations.
module rs_seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] d_reg;

    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] sum;
    logic             no_borrow;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic             accept;

    // Trial subtraction as T + ~{0,D} + 1; carry out of bit WIDTH means no borrow.
    assign trial     = {r_reg, q_reg[WIDTH-1]};
    assign sum       = {1'b0, trial} + {1'b0, ~{1'b0, d_reg}}
                     + {{(WIDTH+1){1'b0}}, 1'b1};
    assign no_borrow = sum[WIDTH+1];
    assign r_next    = no_borrow ? sum[WIDTH-1:0] : trial[WIDTH-1:0];
    assign q_next    = {q_reg[WIDTH-2:0], no_borrow};

    assign accept = start && (state != RUN);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            d_reg       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            q_reg <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            count <= CW'(WIDTH - 1);
            if (divisor == '0) begin
                // Skip iterations entirely; report the conventional all-ones result.
                state       <= DONE;
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                state       <= RUN;
                div_by_zero <= 1'b0;
            end
        end else begin
            case (state)
                RUN: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    if (count == '0) begin
                        state     <= DONE;
                        quotient  <= q_next;
                        remainder <= r_next;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_seq_divider.sv
// Directed and table-driven bench for rs_seq_divider at WIDTH 8, 16 and 2.
module tb_rs_seq_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic       s8_start = 0;
    logic [7:0] s8_a = 0, s8_b = 0;
    logic       s8_busy, s8_done, s8_dz;
    logic [7:0] s8_q, s8_r;

    logic        s16_start = 0;
    logic [15:0] s16_a = 0, s16_b = 0;
    logic        s16_busy, s16_done, s16_dz;
    logic [15:0] s16_q, s16_r;

    logic       s2_start = 0;
    logic [1:0] s2_a = 0, s2_b = 0;
    logic       s2_busy, s2_done, s2_dz;
    logic [1:0] s2_q, s2_r;

    rs_seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8_start),
        .dividend(s8_a), .divisor(s8_b),
        .busy(s8_busy), .done(s8_done),
        .quotient(s8_q), .remainder(s8_r),
        .div_by_zero(s8_dz)
    );

    rs_seq_divider #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(s16_start),
        .dividend(s16_a), .divisor(s16_b),
        .busy(s16_busy), .done(s16_done),
        .quotient(s16_q), .remainder(s16_r),
        .div_by_zero(s16_dz)
    );

    rs_seq_divider #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(s2_start),
        .dividend(s2_a), .divisor(s2_b),
        .busy(s2_busy), .done(s2_done),
        .quotient(s2_q), .remainder(s2_r),
        .div_by_zero(s2_dz)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Wait (bounded) for done; returns edges since the accepting edge and busy cycles.
    task automatic wait8(output int edges, output int busyc);
        edges = 0;
        busyc = 0;
        while (!s8_done && edges < 30) begin
            busyc += int'(s8_busy);
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output int edges, output int busyc);
        @(negedge clk);
        s8_start = 1;
        s8_a = a;
        s8_b = b;
        @(negedge clk);
        s8_start = 0;
        s8_a = 8'hA5;
        s8_b = 8'h5A;
        wait8(edges, busyc);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b);
        int n;
        logic [15:0] eq, er;
        eq = (b == 0) ? 16'hFFFF : a / b;
        er = (b == 0) ? a : a % b;
        @(negedge clk);
        s16_start = 1;
        s16_a = a;
        s16_b = b;
        @(negedge clk);
        s16_start = 0;
        n = 0;
        while (!s16_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("w16_done", {31'd0, s16_done}, 32'd1);
        chk("w16_q", {16'd0, s16_q}, {16'd0, eq});
        chk("w16_r", {16'd0, s16_r}, {16'd0, er});
        chk("w16_dz", {31'd0, s16_dz}, {31'd0, b == 0});
        if (b != 0)
            chk("w16_inv", {16'd0, s16_q} * b + s16_r, {16'd0, a});
    endtask

    task automatic run2(input logic [1:0] a, input logic [1:0] b);
        int n;
        logic [1:0] eq, er;
        eq = (b == 0) ? 2'b11 : a / b;
        er = (b == 0) ? a : a % b;
        @(negedge clk);
        s2_start = 1;
        s2_a = a;
        s2_b = b;
        @(negedge clk);
        s2_start = 0;
        n = 0;
        while (!s2_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("w2_done", {31'd0, s2_done}, 32'd1);
        chk("w2_lat", n, (b == 0) ? 0 : 2);
        chk("w2_q", {30'd0, s2_q}, {30'd0, eq});
        chk("w2_r", {30'd0, s2_r}, {30'd0, er});
        chk("w2_dz", {31'd0, s2_dz}, {31'd0, b == 0});
    endtask

    initial begin
        int edges, busyc, dcount;
        logic [15:0] ra, rb;

        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2, 1'b0};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0, 1'b0};
        vecs[2] = '{8'd3,   8'd10,  8'd0,   8'd3, 1'b0};
        vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0, 1'b0};
        vecs[4] = '{8'd128, 8'd3,   8'd42,  8'd2, 1'b0};
        vecs[5] = '{8'd5,   8'd0,   8'd255, 8'd5, 1'b1};
        vecs[6] = '{8'd9,   8'd4,   8'd2,   8'd1, 1'b0};
        vecs[7] = '{8'd0,   8'd5,   8'd0,   8'd0, 1'b0};
        vecs[8] = '{8'd254, 8'd127, 8'd2,   8'd0, 1'b0};
        vecs[9] = '{8'd7,   8'd8,   8'd0,   8'd7, 1'b0};

        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_busy", {31'd0, s8_busy}, 32'd0);
        chk("rst_done", {31'd0, s8_done}, 32'd0);
        chk("rst_q", {24'd0, s8_q}, 32'd0);
        chk("rst_r", {24'd0, s8_r}, 32'd0);
        chk("rst_dz", {31'd0, s8_dz}, 32'd0);

        foreach (vecs[i]) begin
            run8(vecs[i].a, vecs[i].b, edges, busyc);
            chk("tab_lat", edges, vecs[i].dz ? 0 : 8);
            chk("tab_busy", busyc, vecs[i].dz ? 0 : 8);
            chk("tab_q", {24'd0, s8_q}, {24'd0, vecs[i].q});
            chk("tab_r", {24'd0, s8_r}, {24'd0, vecs[i].r});
            chk("tab_dz", {31'd0, s8_dz}, {31'd0, vecs[i].dz});
            @(negedge clk);
            chk("tab_pulse", {31'd0, s8_done}, 32'd0);
            chk("tab_hold_q", {24'd0, s8_q}, {24'd0, vecs[i].q});
        end

        // Start while busy is ignored; start held in DONE is accepted.
        @(negedge clk);
        s8_start = 1; s8_a = 200; s8_b = 9;
        @(negedge clk);
        s8_start = 0;
        repeat (2) @(negedge clk);
        s8_start = 1; s8_a = 50; s8_b = 5;
        @(negedge clk);
        s8_start = 0;
        wait8(edges, busyc);
        chk("ign_done", {31'd0, s8_done}, 32'd1);
        chk("ign_q", {24'd0, s8_q}, 32'd22);
        chk("ign_r", {24'd0, s8_r}, 32'd2);
        s8_start = 1; s8_a = 50; s8_b = 5;
        @(negedge clk);
        s8_start = 0;
        chk("b2b_busy", {31'd0, s8_busy}, 32'd1);
        chk("b2b_hold_q", {24'd0, s8_q}, 32'd22);
        wait8(edges, busyc);
        chk("b2b_lat", edges, 8);
        chk("b2b_q", {24'd0, s8_q}, 32'd10);
        chk("b2b_r", {24'd0, s8_r}, 32'd0);

        // Back-to-back divide by zero.
        @(negedge clk);
        s8_start = 1; s8_a = 5; s8_b = 0;
        @(negedge clk);
        chk("dz1_done", {31'd0, s8_done}, 32'd1);
        s8_a = 6;
        @(negedge clk);
        s8_start = 0;
        chk("dz2_done", {31'd0, s8_done}, 32'd1);
        chk("dz2_busy", {31'd0, s8_busy}, 32'd0);
        chk("dz2_r", {24'd0, s8_r}, 32'd6);
        chk("dz2_q", {24'd0, s8_q}, 32'd255);
        @(negedge clk);
        chk("dz2_end", {31'd0, s8_done}, 32'd0);

        // Asynchronous reset in the middle of a run.
        s8_start = 1; s8_a = 100; s8_b = 7;
        @(negedge clk);
        s8_start = 0;
        repeat (3) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("arst_busy", {31'd0, s8_busy}, 32'd0);
        chk("arst_q", {24'd0, s8_q}, 32'd0);
        chk("arst_r", {24'd0, s8_r}, 32'd0);
        chk("arst_dz", {31'd0, s8_dz}, 32'd0);
        @(negedge clk);
        rst = 0;
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            dcount += int'(s8_done);
        end
        chk("arst_nodone", dcount, 0);
        run8(8'd77, 8'd8, edges, busyc);
        chk("post_q", {24'd0, s8_q}, 32'd9);
        chk("post_r", {24'd0, s8_r}, 32'd5);

        // Exhaustive at WIDTH=2.
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                run2(2'(a), 2'(b));

        // Random at WIDTH=16, with corner operands mixed in.
        for (int k = 0; k < 1500; k++) begin
            ra = 16'($urandom);
            case (k % 5)
                0: rb = 16'($urandom_range(0, 15));
                1: rb = 16'($urandom_range(0, 255));
                2: rb = 16'hFFFF - 16'($urandom_range(0, 3));
                default: rb = 16'($urandom);
            endcase
            if (k % 97 == 0) rb = 16'd0;
            if (k % 89 == 0) ra = 16'hFFFF;
            run16(ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
